// File: rtl/vc_rr_arbiter_pkg.sv
// Shared definitions for the VC round-robin arbiter: FSM encodings and width.
package vc_rr_arbiter_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

endpackage

// File: rtl/vc_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr
// (wrapping modulo N) wins; grant is one-hot, grant_idx is its encoding.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx,
    output logic          grant_valid
);

    // Candidate index for each scan offset: (ptr + offset) mod N.
    logic [PW-1:0] cand_idx [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [PW:0] sum;
            assign sum          = {1'b0, ptr} + (PW+1)'(gi);
            assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N))
                                                      : sum[PW-1:0];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[cand_idx[k]]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[k];
            end
        end
    end

    assign grant = grant_valid ? (N'(1) << grant_idx) : '0;

endmodule

// File: rtl/vc_rr_arbiter.sv
// Per-VC FIFO bank drain: round-robin pops one word per cycle into the egress
// FIFO under almost-full backpressure, owns the FIFO thresholds and the
// sticky datapath error state.
module vc_rr_arbiter
    import vc_rr_arbiter_pkg::*;
#(
    parameter int BW = 6,
    parameter int N  = 4,
    parameter int UW = 16
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic [UW-1:0]     umbral_bajo_in,
    input  logic [UW-1:0]     umbral_alto_in,
    output logic [UW-1:0]     umbral_bajo,
    output logic [UW-1:0]     umbral_alto,
    input  logic [N-1:0]      fifo_empty,
    input  logic [N-1:0]      fifo_error,
    input  logic [N*BW-1:0]   fifo_data,
    output logic [N-1:0]      fifo_rd,
    input  logic              egress_almost_full,
    output logic [BW-1:0]     data_out,
    output logic              valid_out,
    output logic [STATE_W-1:0] state,
    output logic              idle_out,
    output logic              error_out
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    state_t        state_reg, state_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic [BW-1:0] data_out_reg;
    logic          valid_out_reg;
    logic [UW-1:0] umbral_bajo_reg, umbral_alto_reg;

    logic          any_error;
    logic          all_empty;
    logic          arb_en;
    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic [PW-1:0] grant_idx;
    logic          grant_valid;
    logic [BW-1:0] word [N];

    assign any_error = |fifo_error;
    assign all_empty = &fifo_empty;
    assign arb_en    = (state_reg == ST_ACTIVE) && !egress_almost_full;
    assign req       = arb_en ? ~fifo_empty : '0;

    // Unpack the flat read-data bus into one word per VC.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_word
            assign word[gi] = fifo_data[gi*BW +: BW];
        end
    endgenerate

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req         (req),
        .ptr         (ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign fifo_rd = grant;

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
        end
    end

    // Next-state logic; an error flag pre-empts every other transition.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET: state_next = ST_INIT;
            ST_INIT: begin
                if (any_error)  state_next = ST_ERROR;
                else if (!init) state_next = ST_IDLE;
            end
            ST_IDLE, ST_ACTIVE: begin
                if (any_error)      state_next = ST_ERROR;
                else if (init)      state_next = ST_INIT;
                else if (all_empty) state_next = ST_IDLE;
                else                state_next = ST_ACTIVE;
            end
            ST_ERROR: state_next = ST_ERROR;
            default:  state_next = ST_RESET;
        endcase
    end

    // State, pointer, forwarded word and threshold registers.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_reg       <= ST_RESET;
            ptr_reg         <= '0;
            data_out_reg    <= '0;
            valid_out_reg   <= 1'b0;
            umbral_bajo_reg <= '0;
            umbral_alto_reg <= '0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            valid_out_reg <= grant_valid;
            if (grant_valid) begin
                data_out_reg <= word[grant_idx];
            end
            if (state_reg == ST_INIT) begin
                umbral_bajo_reg <= umbral_bajo_in;
                umbral_alto_reg <= umbral_alto_in;
            end
        end
    end

    assign state       = state_reg;
    assign idle_out    = (state_reg == ST_IDLE);
    assign error_out   = (state_reg == ST_ERROR);
    assign data_out    = data_out_reg;
    assign valid_out   = valid_out_reg;
    assign umbral_bajo = umbral_bajo_reg;
    assign umbral_alto = umbral_alto_reg;

endmodule

// File: doc/vc_rr_arbiter.md
# vc_rr_arbiter

Downstream stage of the per-VC FIFO bank in the QoS datapath. Pops words from N virtual-channel FIFOs with round-robin fairness and forwards one word per cycle to a single egress FIFO, honouring the egress almost-full backpressure. Also owns the FIFO threshold configuration (INIT phase) and the datapath error state, aggregating the FIFOs' error flags.

## Interface
Parameters:
- BW, 6, data word width (matches FIFO BW)
- N, 4, number of VC FIFOs arbitrated
- UW, 16, threshold width (matches FIFO LEN)

Ports:
- clk  in  1  single clock, rising edge
- reset_L  in  1  asynchronous active-low reset
- init  in  1  request (re)configuration; held high to stay in INIT
- umbral_bajo_in  in  UW  almost-empty threshold, latched in INIT
- umbral_alto_in  in  UW  almost-full threshold, latched in INIT
- umbral_bajo  out  UW  registered threshold driven to all VC FIFOs
- umbral_alto  out  UW  registered threshold driven to all VC FIFOs
- fifo_empty  in  N  per-VC FIFO empty flags
- fifo_error  in  N  per-VC FIFO error_output flags
- fifo_data  in  N*BW  per-VC FIFO read data; slice i = bits [i*BW +: BW]; valid only while fifo_rd[i] is high (combinational read)
- fifo_rd  out  N  per-VC pop, at most one bit set (one-hot or zero)
- egress_almost_full  in  1  backpressure from egress FIFO
- data_out  out  BW  registered forwarded word
- valid_out  out  1  registered; write strobe to egress FIFO
- state  out  3  current FSM state
- idle_out  out  1  high when state==IDLE
- error_out  out  1  high when state==ERROR

## Operation
- FSM states: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET: held while reset_L low; first clock after release -> INIT.
- INIT: umbral_bajo/umbral_alto load from *_in every cycle. init low -> IDLE.
- IDLE: all fifo_empty high -> stay; any low -> ACTIVE.
- ACTIVE: arbitration enabled; all fifo_empty high -> IDLE.
- From IDLE or ACTIVE: init high -> INIT.
- From INIT, IDLE or ACTIVE: any fifo_error bit high -> ERROR, priority over every other transition. ERROR is sticky; only reset_L exits.
- Grant (combinational): only in ACTIVE with egress_almost_full low. Scan indices ptr, ptr+1, ... mod N; first with fifo_empty low is granted; fifo_rd = onehot(granted). No grant otherwise, fifo_rd = 0.
- On grant i: data_out <= fifo_data slice i, valid_out <= 1, ptr <= (i==N-1) ? 0 : i+1. No grant: valid_out <= 0, data_out and ptr hold.
- Never pops an empty FIFO; no pops in RESET, INIT, IDLE or ERROR.
- Thresholds hold their value outside INIT.

## Timing
- Async reset values: state=RESET, ptr=0, data_out=0, valid_out=0, umbral_bajo=0, umbral_alto=0; fifo_rd=0 (derived from state).
- FIFO goes non-empty in cycle t (IDLE) -> ACTIVE at t+1 -> fifo_rd high during t+1 -> valid_out/data_out at t+2.
- Pop-to-valid_out latency: 1 cycle. Throughput: 1 word/cycle while granted.
- egress_almost_full sampled combinationally: high in cycle t -> fifo_rd=0 in t -> valid_out=0 at t+1.
- fifo_error and init in the same cycle -> ERROR.
- reset_L low mid-transfer: all registers clear immediately; in-flight word is dropped.
- Single non-empty FIFO: granted every cycle regardless of ptr.

## Structure
- Shared package: state encodings (RESET..ERROR) and the 3-bit state width, reused by the datapath top and the checker.
- One sub-module: rr_pick (combinational: N-bit request vector and ptr in, one-hot grant and encoded index out). FSM, ptr, threshold registers and output registers live in vc_rr_arbiter.

## Test plan
- Reset then init=1 for 2 cycles with umbral_bajo_in=2, umbral_alto_in=12; then init=0 -> state INIT->IDLE, umbral_bajo=2, umbral_alto=12, held after init drops.
- All 4 FIFOs non-empty with 2 words each, egress_almost_full=0 -> fifo_rd order 0,1,2,3,0,1,2,3; valid_out 8 cycles, each data_out matches the popped word; returns to IDLE.
- FIFO 2 only non-empty with 3 words -> fifo_rd=4'b0100 three consecutive cycles, then IDLE.
- Streaming, egress_almost_full high for 3 cycles -> fifo_rd=0 and valid_out=0 during the stall (one cycle lagged); round-robin resumes from the saved ptr.
- fifo_error[1] pulses for one cycle in ACTIVE -> state=ERROR next cycle, error_out=1, fifo_rd=0 permanently until reset_L low.
- reset_L asserted mid-stream -> valid_out, data_out, ptr, thresholds read 0 immediately; state=RESET.
